module_keypad_scanner: RTL and testbench

//  Drives the 4x4 matrix keypad of the multiplier front end: rotates an active-low row strobe,

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/module_sync2.sv | 28 ++
 rtl/module_keypad_scanner.sv | 122 ++++++++++++
 tb/tb_module_keypad_scanner.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key codes and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic {SCAN, HOLD} scan_state_t;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Keypad layout: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
  function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    if (col == 2'd3) begin
      code = KEY_A + {2'b00, row};
    end else if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'h0;
        default: code = KEY_HASH;
      endcase
    end else begin
      // digits 1..9 laid out row-major, three per row
      code = ({2'b00, row} << 1) + {2'b00, row} + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  // Index of the lowest-numbered column pulled low; column 0 wins on multi-press.
  function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/module_sync2.sv
// N-bit two-flop synchronizer with a configurable reset value.
module module_sync2 #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // Two back-to-back flops to settle asynchronous keypad inputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/module_keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, captures the
// first closed key and holds its code until the column has stayed open long enough.
module module_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int RELEASE_CNT = 16
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int REL_W   = $clog2(RELEASE_CNT + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [REL_W-1:0]   REL_LAST   = REL_W'(RELEASE_CNT - 1);

  logic [3:0] col_s;

  scan_state_t        state_reg,      state_next;
  logic [1:0]         row_idx_reg,    row_idx_next;
  logic [DWELL_W-1:0] dwell_cnt_reg,  dwell_cnt_next;
  logic [REL_W-1:0]   rel_cnt_reg,    rel_cnt_next;
  logic [1:0]         hold_col_reg,   hold_col_next;
  logic [3:0]         key_code_reg,   key_code_next;
  logic               key_valid_reg,  key_valid_next;
  logic               key_strobe_reg, key_strobe_next;

  module_sync2 #(
    .WIDTH     (4),
    .RESET_VAL (4'b1111)
  ) u_col_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (col_in),
    .q       (col_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg      <= SCAN;
      row_idx_reg    <= 2'd0;
      dwell_cnt_reg  <= '0;
      rel_cnt_reg    <= '0;
      hold_col_reg   <= 2'd0;
      key_code_reg   <= 4'h0;
      key_valid_reg  <= 1'b0;
      key_strobe_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_idx_reg    <= row_idx_next;
      dwell_cnt_reg  <= dwell_cnt_next;
      rel_cnt_reg    <= rel_cnt_next;
      hold_col_reg   <= hold_col_next;
      key_code_reg   <= key_code_next;
      key_valid_reg  <= key_valid_next;
      key_strobe_reg <= key_strobe_next;
    end
  end

  // Scan/hold sequencing: sample columns at the end of each row dwell,
  // then wait for the captured column to read open for RELEASE_CNT cycles.
  always_comb begin
    state_next      = state_reg;
    row_idx_next    = row_idx_reg;
    dwell_cnt_next  = dwell_cnt_reg;
    rel_cnt_next    = rel_cnt_reg;
    hold_col_next   = hold_col_reg;
    key_code_next   = key_code_reg;
    key_valid_next  = key_valid_reg;
    key_strobe_next = 1'b0;
    case (state_reg)
      SCAN: begin
        if (dwell_cnt_reg == DWELL_LAST) begin
          dwell_cnt_next = '0;
          if (col_s == 4'b1111) begin
            row_idx_next = row_idx_reg + 2'd1;
          end else begin
            key_code_next   = encode_key(row_idx_reg, lowest_low_col(col_s));
            hold_col_next   = lowest_low_col(col_s);
            key_strobe_next = 1'b1;
            key_valid_next  = 1'b1;
            rel_cnt_next    = '0;
            state_next      = HOLD;
          end
        end else begin
          dwell_cnt_next = dwell_cnt_reg + DWELL_W'(1);
        end
      end
      HOLD: begin
        dwell_cnt_next = '0;
        if (col_s[hold_col_reg]) begin
          if (rel_cnt_reg == REL_LAST) begin
            // Open long enough: resume scanning on the following row, keep the code.
            rel_cnt_next   = '0;
            key_valid_next = 1'b0;
            row_idx_next   = row_idx_reg + 2'd1;
            state_next     = SCAN;
          end else begin
            rel_cnt_next = rel_cnt_reg + REL_W'(1);
          end
        end else begin
          // Contact bounced closed again: restart the release count.
          rel_cnt_next = '0;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  assign row_out    = ~(4'b0001 << row_idx_reg);
  assign key_code   = key_code_reg;
  assign key_valid  = key_valid_reg;
  assign key_strobe = key_strobe_reg;

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Self-checking bench for module_keypad_scanner with a physical keypad model
// and a timestamp-based reference model of the scan/hold behaviour.
module tb_module_keypad_scanner;

  localparam int SCAN_DIV    = 8;
  localparam int RELEASE_CNT = 4;

  logic       clk;
  logic       n_reset;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_strobe;

  // pressed[r][c] = 1 when the key at row r, column c is physically closed
  logic [3:0] pressed [4];

  int n_vec;
  int n_err;
  int n_strobes;

  // reference model state
  int         cyc;
  bit         m_hold;
  int         m_row;
  int         row_start;
  int         last_low;
  int         m_hcol;
  logic [3:0] m_code;
  bit         m_valid;
  bit         m_strobe;
  logic [3:0] hist [3];

  module_keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .RELEASE_CNT (RELEASE_CNT)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .col_in     (col_in),
    .row_out    (row_out),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_strobe (key_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulled-up columns go low where a closed key sits on the driven row.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (!row_out[r]) col_in = col_in & ~pressed[r];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Key value straight from the printed keypad legend.
  function automatic logic [3:0] key_of(input int r, input int c);
    string layout;
    byte   ch;
    layout = "123A456B789C*0#D";
    ch = layout[r*4 + c];
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
    if (ch == "*") return 4'hE;
    return 4'hF;
  endfunction

  task automatic model_reset();
    cyc = 0; m_hold = 0; m_row = 0; row_start = 0; last_low = 0; m_hcol = 0;
    m_code = 4'h0; m_valid = 0; m_strobe = 0;
    for (int i = 0; i < 3; i++) hist[i] = 4'hF;
  endtask

  // Predict the effect of clock edge number cyc; the scanner acts on columns
  // as they were two edges earlier.
  task automatic model_edge();
    logic [3:0] cs;
    int c;
    cs = hist[2];
    m_strobe = 0;
    if (!m_hold) begin
      if (cyc - row_start == SCAN_DIV - 1) begin
        if (cs == 4'hF) begin
          m_row = (m_row + 1) % 4;
          row_start = cyc + 1;
        end else begin
          c = 0;
          for (int i = 3; i >= 0; i--) if (!cs[i]) c = i;
          m_code = key_of(m_row, c);
          m_hcol = c;
          m_valid = 1; m_strobe = 1; m_hold = 1;
          last_low = cyc;
        end
      end
    end else begin
      if (!cs[m_hcol]) last_low = cyc;
      else if (cyc - last_low >= RELEASE_CNT) begin
        m_valid = 0; m_hold = 0;
        m_row = (m_row + 1) % 4;
        row_start = cyc + 1;
      end
    end
    cyc++;
  endtask

  // One clock: sample columns, advance model, compare outputs at the negedge.
  task automatic tick();
    logic [3:0] er;
    #1;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = col_in;
    model_edge();
    @(negedge clk);
    if (key_strobe) n_strobes++;
    er = 4'b1111;
    er[m_row] = 1'b0;
    check_val("row_out",    32'(row_out),    32'(er));
    check_val("key_code",   32'(key_code),   32'(m_code));
    check_val("key_valid",  32'(key_valid),  32'(m_valid));
    check_val("key_strobe", 32'(key_strobe), 32'(m_strobe));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must respond at once.
  task automatic do_reset();
    #2 n_reset = 1'b0;
    #1;
    check_val("rst_row_out",    32'(row_out),    32'h0000000E);
    check_val("rst_key_code",   32'(key_code),   32'h0);
    check_val("rst_key_valid",  32'(key_valid),  32'h0);
    check_val("rst_key_strobe", 32'(key_strobe), 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!key_valid && k < 64) begin
      tick();
      k++;
    end
    check_val("capture_wait", 32'(key_valid), 32'h1);
  endtask

  task automatic press_check(input int r, input int c, input logic [3:0] exp);
    n_strobes = 0;
    pressed[r][c] = 1'b1;
    wait_valid();
    ticks(3);
    check_val("press_code", 32'(key_code), 32'(exp));
    pressed[r] = 4'b0000;
    ticks(12);
    check_val("press_strobes", 32'(n_strobes), 32'h1);
    check_val("press_released", 32'(key_valid), 32'h0);
    check_val("press_code_kept", 32'(key_code), 32'(exp));
  endtask

  initial begin
    int r, c, c2;
    logic [3:0] saved;
    n_vec = 0; n_err = 0; n_strobes = 0;
    for (int i = 0; i < 4; i++) pressed[i] = 4'b0000;
    n_reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    ticks(5);

    // 1: reset mid-cycle, then idle row rotation
    do_reset();
    ticks(8);  check_val("t1_row1", 32'(row_out), 32'hD);
    ticks(8);  check_val("t1_row2", 32'(row_out), 32'hB);
    ticks(8);  check_val("t1_row3", 32'(row_out), 32'h7);
    ticks(8);  check_val("t1_row0", 32'(row_out), 32'hE);

    // 2: press '5'
    n_strobes = 0;
    pressed[1][1] = 1'b1;
    wait_valid();
    ticks(5);
    check_val("t2_code", 32'(key_code), 32'h5);
    check_val("t2_row_frozen", 32'(row_out), 32'hD);
    pressed[1][1] = 1'b0;
    ticks(12);
    check_val("t2_valid_off", 32'(key_valid), 32'h0);
    check_val("t2_code_kept", 32'(key_code), 32'h5);
    check_val("t2_strobes", 32'(n_strobes), 32'h1);

    // 3: '#', '*', 'A'
    press_check(3, 2, 4'hF);
    press_check(3, 0, 4'hE);
    press_check(0, 3, 4'hA);

    // 4: short bounce does not release; long open does
    n_strobes = 0;
    pressed[1][1] = 1'b1;
    wait_valid();
    ticks(3);
    pressed[1][1] = 1'b0;
    ticks(2);
    pressed[1][1] = 1'b1;
    ticks(10);
    check_val("t4_still_valid", 32'(key_valid), 32'h1);
    check_val("t4_one_strobe", 32'(n_strobes), 32'h1);
    check_val("t4_row_held", 32'(row_out), 32'hD);
    pressed[1][1] = 1'b0;
    ticks(8);
    check_val("t4_valid_off", 32'(key_valid), 32'h0);
    check_val("t4_next_row", 32'(row_out), 32'hB);

    // 5: '8' + 'C' together -> lowest column wins
    pressed[2][3] = 1'b1;
    press_check(2, 1, 4'h8);

    // 6: reset while holding, key recaptured afterwards
    pressed[1][1] = 1'b1;
    wait_valid();
    ticks(2);
    do_reset();
    n_strobes = 0;
    wait_valid();
    ticks(2);
    check_val("t6_recapture_code", 32'(key_code), 32'h5);
    check_val("t6_recapture_strobes", 32'(n_strobes), 32'h1);
    pressed[1][1] = 1'b0;
    ticks(12);

    // randomized presses, multi-presses and bounces
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      n_strobes = 0;
      pressed[r][c] = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        c2 = $urandom_range(0, 3);
        pressed[r][c2] = 1'b1;
      end
      wait_valid();
      ticks($urandom_range(0, 10));
      repeat ($urandom_range(0, 2)) begin
        saved = pressed[r];
        pressed[r] = 4'b0000;
        ticks($urandom_range(1, 3));
        pressed[r] = saved;
        ticks($urandom_range(1, 5));
      end
      pressed[r] = 4'b0000;
      ticks(12);
      check_val("rand_strobes", 32'(n_strobes), 32'h1);
      check_val("rand_released", 32'(key_valid), 32'h0);
      ticks($urandom_range(0, 20));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
